// File: rtl/alu_commit_arbiter.sv
// alu_commit_arbiter: round-robin sharing of the register-file writeback port between execution units
package core_config_pkg;
  localparam int XLEN = 32;
  localparam int REG_ADDR_W = 5;
endpackage

module alu_commit_arbiter #(
  parameter int N_UNITS = 4,
  parameter int XLEN = core_config_pkg::XLEN,
  parameter int REG_ADDR_W = core_config_pkg::REG_ADDR_W,
  localparam int SW = $clog2(N_UNITS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_UNITS*XLEN-1:0]       u_res,
  input  logic [N_UNITS*REG_ADDR_W-1:0] u_rd,
  input  logic [N_UNITS-1:0]            u_valid,
  input  logic [N_UNITS-1:0]            u_error,
  input  logic [N_UNITS-1:0]            u_req,
  output logic [N_UNITS-1:0]            u_clear,
  input  logic                          flush,
  output logic                          wb_valid,
  input  logic                          wb_ready,
  output logic                          wb_we,
  output logic [REG_ADDR_W-1:0]         wb_rd,
  output logic [XLEN-1:0]               wb_data,
  output logic                          wb_error,
  output logic [SW-1:0]                 wb_src
);
  localparam logic [SW:0] NU = (SW+1)'(N_UNITS);
  logic [XLEN-1:0]       res_a [N_UNITS];
  logic [REG_ADDR_W-1:0] rd_a [N_UNITS];
  logic [N_UNITS-1:0]    cand, clr_q, clr_d;
  logic                  stage_free, gnt_v;
  logic [SW-1:0]         gnt, ptr_q, ptr_d, wb_src_q;
  logic                  wb_valid_q, wb_we_q, wb_error_q;
  logic [REG_ADDR_W-1:0] wb_rd_q;
  logic [XLEN-1:0]       wb_data_q;

  // Explicit modulo so a non-power-of-two unit count wraps correctly.
  function automatic logic [SW-1:0] wrap(input logic [SW:0] v);
    return (v >= NU) ? SW'(v - NU) : v[SW-1:0];
  endfunction

  // A unit being cleared this cycle still shows req/valid; mask it to avoid a double grant.
  assign cand = u_req & u_valid & ~clr_q;
  assign stage_free = ~wb_valid_q | wb_ready;

  // Split the flat per-unit buses into indexable arrays.
  always_comb begin
    for (int i = 0; i < N_UNITS; i++) begin
      res_a[i] = u_res[i*XLEN +: XLEN];
      rd_a[i] = u_rd[i*REG_ADDR_W +: REG_ADDR_W];
    end
  end

  // Round-robin pick: scan downward so the candidate nearest the pointer wins last.
  always_comb begin
    gnt_v = 1'b0;
    gnt = '0;
    for (int k = N_UNITS-1; k >= 0; k--) begin
      if (cand[wrap({1'b0, ptr_q} + (SW+1)'(k))]) begin
        gnt_v = 1'b1;
        gnt = wrap({1'b0, ptr_q} + (SW+1)'(k));
      end
    end
    gnt_v = gnt_v & stage_free & ~flush;
    ptr_d = gnt_v ? wrap({1'b0, gnt} + (SW+1)'(1)) : ptr_q;
    clr_d = flush ? u_req : gnt_v ? N_UNITS'(1) << gnt : '0;
  end

  // Writeback stage, pointer and clear pulses; flush drops the stage and clears every requester.
  always_ff @(posedge clk) begin
    if (rst) begin
      clr_q <= '0;
      ptr_q <= '0;
      wb_valid_q <= 1'b0;
      wb_we_q <= 1'b0;
      wb_error_q <= 1'b0;
      wb_rd_q <= '0;
      wb_data_q <= '0;
      wb_src_q <= '0;
    end else begin
      clr_q <= clr_d;
      ptr_q <= ptr_d;
      if (flush) begin
        wb_valid_q <= 1'b0;
        wb_we_q <= 1'b0;
        wb_error_q <= 1'b0;
      end else if (gnt_v) begin
        wb_valid_q <= 1'b1;
        wb_we_q <= ~u_error[gnt] & (rd_a[gnt] != '0);
        wb_error_q <= u_error[gnt];
        wb_rd_q <= rd_a[gnt];
        wb_data_q <= res_a[gnt];
        wb_src_q <= gnt;
      end else if (wb_ready) begin
        wb_valid_q <= 1'b0;
        wb_we_q <= 1'b0;
      end
    end
  end

  assign u_clear = clr_q;
  assign wb_valid = wb_valid_q;
  assign wb_we = wb_we_q;
  assign wb_error = wb_error_q;
  assign wb_rd = wb_rd_q;
  assign wb_data = wb_data_q;
  assign wb_src = wb_src_q;
endmodule
